// File: rtl/rom_pkg.sv
// Shared types and constants for the burst-reading ROM.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rom_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Even parity bit: the value that makes the XOR over data plus parity zero.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rom_burst_reader.sv
// Parametrised ROM streaming a wrap-around burst of consecutive words per command.
// Latency: start to first data_valid is 2 cycles; one beat per cycle after that.
// Backpressure: data_valid & !data_ready holds data_out/data_last and stalls reads.
// Optional parity checking is built only when ROM_PARITY_EN is defined.
module rom_burst_reader
    import rom_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] burst_len,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last
`ifdef ROM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef ROM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Contents are loaded from outside through the instance hierarchy.
    logic [MEM_W-1:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [MEM_W-1:0]  rd_word;
    logic              slot_free;
`ifdef ROM_PARITY_EN
    logic              perr_q, perr_d;
`endif

    assign rd_word   = mem[ptr_q];
    assign slot_free = !vld_q || data_ready;

    // State and output registers; reset also aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef ROM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
`ifdef ROM_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: accept a command, issue reads into a free slot, drain the last beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
`ifdef ROM_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = start_addr;
                    rem_d   = burst_len;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (slot_free) begin
                    data_d = rd_word[DATA_W-1:0];
                    vld_d  = 1'b1;
                    last_d = (rem_q == '0);
`ifdef ROM_PARITY_EN
                    perr_d = rd_word[DATA_W] != even_parity(32'(rd_word[DATA_W-1:0]));
`endif
                    // Wrap explicitly so DEPTH need not be a power of two.
                    ptr_d  = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (vld_q && data_ready) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
`ifdef ROM_PARITY_EN
                    perr_d  = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign data_out   = data_q;
    assign data_valid = vld_q;
    assign data_last  = last_q;
`ifdef ROM_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
